// File: rtl/sram_write_timer_if.sv
// Bus between the SRAM write timer and its job source, data producer and SRAM.
interface sram_write_timer_if #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned CNT_BITS  = 10
);
  logic                 start_write;
  logic [ADDR_BITS-1:0] base_addr;
  logic [CNT_BITS-1:0]  byte_count;
  logic [7:0]           data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic [ADDR_BITS-1:0] sram_addr;
  logic [7:0]           sram_wdata;
  logic                 sram_wen;
  logic                 write_busy;
  logic                 write_done;

  // Job source / producer side
  modport master (
    output start_write, base_addr, byte_count, data_in, data_valid,
    input  data_ready, sram_addr, sram_wdata, sram_wen, write_busy, write_done
  );

  // Write timer side
  modport slave (
    input  start_write, base_addr, byte_count, data_in, data_valid,
    output data_ready, sram_addr, sram_wdata, sram_wen, write_busy, write_done
  );
endinterface

// File: rtl/sram_write_timer.sv
// Sequences byte writes into the external SRAM, holding each byte on the
// SRAM pins with the write strobe for WRITE_CYCLES clocks.
module sram_write_timer #(
  parameter int unsigned ADDR_BITS    = 16,
  parameter int unsigned CNT_BITS     = 10,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  sram_write_timer_if.slave   bus
);

  localparam int unsigned CYC_BITS = 4;
  localparam logic [CYC_BITS-1:0] LAST_CYC = CYC_BITS'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [CNT_BITS-1:0]   remaining_q, remaining_d;
  logic [CYC_BITS-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                  data_ready_q, data_ready_d;
  logic                  sram_wen_q, sram_wen_d;
  logic                  write_busy_q, write_busy_d;
  logic                  write_done_q, write_done_d;

  // Next-state, datapath and output decode; outputs follow the next state so
  // they line up with the registered state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    remaining_d  = remaining_q;
    cycle_cnt_d  = cycle_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start_write) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.byte_count;
          state_d     = (bus.byte_count == '0) ? DONE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.data_valid) begin
          data_d      = bus.data_in;
          cycle_cnt_d = '0;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        cycle_cnt_d = cycle_cnt_q + CYC_BITS'(1);
        if (cycle_cnt_q == LAST_CYC) begin
          addr_d      = addr_q + ADDR_BITS'(1);
          remaining_d = remaining_q - CNT_BITS'(1);
          state_d     = (remaining_q == CNT_BITS'(1)) ? DONE : WAIT_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_ready_d = (state_d == WAIT_DATA);
    sram_wen_d   = (state_d == WRITE);
    write_busy_d = (state_d == WAIT_DATA) || (state_d == WRITE);
    write_done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      remaining_q  <= '0;
      cycle_cnt_q  <= '0;
      data_ready_q <= 1'b0;
      sram_wen_q   <= 1'b0;
      write_busy_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      remaining_q  <= remaining_d;
      cycle_cnt_q  <= cycle_cnt_d;
      data_ready_q <= data_ready_d;
      sram_wen_q   <= sram_wen_d;
      write_busy_q <= write_busy_d;
      write_done_q <= write_done_d;
    end
  end

  assign bus.data_ready = data_ready_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = data_q;
  assign bus.sram_wen   = sram_wen_q;
  assign bus.write_busy = write_busy_q;
  assign bus.write_done = write_done_q;

endmodule

// File: tb/tb_sram_write_timer.sv
// Directed bench for sram_write_timer with WRITE_CYCLES=2.
module tb_sram_write_timer;

  localparam int unsigned ADDR_BITS = 16;
  localparam int unsigned CNT_BITS  = 10;

  logic clk;
  logic n_rst;
  logic hold;
  int   n_tests;
  int   n_fail;
  int   done_cnt;
  logic [7:0]  prod_q[$];
  logic [23:0] wr_q[$];

  sram_write_timer_if #(.ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)) bus ();

  sram_write_timer #(
    .ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS), .WRITE_CYCLES(2)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.write_done && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.write_done), 32'd1);
  endtask

  task automatic check_writes(input string tag, input logic [23:0] exp[$]);
    logic [31:0] got;
    check({tag, "_n"}, 32'(wr_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_w%0d", tag, i), got, 32'(exp[i]));
    end
  endtask

  // Producer: presents the head of prod_q, pops it once the handshake fires
  initial begin
    logic fire;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    forever begin
      @(negedge clk);
      fire = bus.data_valid && bus.data_ready && n_rst;
      @(posedge clk);
      #2;
      if (fire && prod_q.size() > 0) void'(prod_q.pop_front());
      bus.data_valid = (prod_q.size() > 0) && !hold;
      bus.data_in    = (prod_q.size() > 0) ? prod_q[0] : 8'h00;
    end
  end

  // SRAM-side monitor: logs every strobed cycle and counts done pulses
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.sram_wen) wr_q.push_back({bus.sram_addr, bus.sram_wdata});
      if (bus.write_done) done_cnt++;
    end
  end

  initial begin
    logic [11:0] exp_ready, exp_wen, exp_busy, exp_done;
    logic [7:0]  exp_bytes[3];
    logic [23:0] ew[$];
    int idx, n, done_before;

    n_tests = 0;
    n_fail  = 0;
    hold    = 1'b0;
    n_rst   = 1'b0;
    bus.start_write = 1'b1;
    bus.base_addr   = 16'h0000;
    bus.byte_count  = 10'd1;
    prod_q.push_back(8'h99);

    // 1: reset with start and data_valid asserted
    tick();
    tick();
    check("rst_ready", 32'(bus.data_ready), 32'd0);
    check("rst_wen",   32'(bus.sram_wen),   32'd0);
    check("rst_busy",  32'(bus.write_busy), 32'd0);
    check("rst_done",  32'(bus.write_done), 32'd0);
    check("rst_addr",  32'(bus.sram_addr),  32'd0);
    check("rst_wdata", 32'(bus.sram_wdata), 32'd0);
    bus.start_write = 1'b0;
    n_rst = 1'b1;
    wr_q.delete();
    for (int i = 0; i < 5; i++) tick();
    check("rst_nowr",   32'(wr_q.size()),   32'd0);
    check("rst_idle",   32'(bus.write_busy), 32'd0);
    prod_q.delete();
    tick();

    // 2: basic three-byte job, data_valid held high
    exp_ready = 12'h092;
    exp_wen   = 12'h36C;
    exp_busy  = 12'h3FE;
    exp_done  = 12'h400;
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3;
    prod_q.push_back(8'hA1); prod_q.push_back(8'hB2); prod_q.push_back(8'hC3);
    bus.base_addr   = 16'h0100;
    bus.byte_count  = 10'd3;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      check($sformatf("basic_ready_c%0d", k), 32'(bus.data_ready), 32'(exp_ready[k]));
      check($sformatf("basic_wen_c%0d", k),   32'(bus.sram_wen),   32'(exp_wen[k]));
      check($sformatf("basic_busy_c%0d", k),  32'(bus.write_busy), 32'(exp_busy[k]));
      check($sformatf("basic_done_c%0d", k),  32'(bus.write_done), 32'(exp_done[k]));
      if (exp_wen[k]) begin
        idx = (k - 2) / 3;
        check($sformatf("basic_addr_c%0d", k),  32'(bus.sram_addr),  32'h0100 + 32'(idx));
        check($sformatf("basic_wdata_c%0d", k), 32'(bus.sram_wdata), 32'(exp_bytes[idx]));
      end
      tick();
    end

    // 3: zero-length job
    wr_q.delete();
    bus.byte_count  = 10'd0;
    bus.base_addr   = 16'h0123;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    check("zero_done",  32'(bus.write_done), 32'd1);
    check("zero_ready", 32'(bus.data_ready), 32'd0);
    check("zero_busy",  32'(bus.write_busy), 32'd0);
    tick();
    check("zero_done_once", 32'(bus.write_done), 32'd0);
    tick();
    check("zero_nowr", 32'(wr_q.size()), 32'd0);

    // 4: address wrap at 0xFFFF
    wr_q.delete();
    prod_q.push_back(8'h11); prod_q.push_back(8'h22);
    bus.base_addr   = 16'hFFFF;
    bus.byte_count  = 10'd2;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    wait_done("wrap_done", 20);
    tick();
    check("wrap_done_once", 32'(bus.write_done), 32'd0);
    ew = '{24'hFFFF11, 24'hFFFF11, 24'h000022, 24'h000022};
    check_writes("wrap", ew);

    // 5: back-pressure plus a start pulse mid-job
    wr_q.delete();
    hold = 1'b1;
    prod_q.push_back(8'h55); prod_q.push_back(8'h66);
    bus.base_addr   = 16'h0300;
    bus.byte_count  = 10'd2;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.base_addr   = 16'h0200;
        bus.byte_count  = 10'd7;
        bus.start_write = 1'b1;
      end else begin
        bus.start_write = 1'b0;
      end
      tick();
      check($sformatf("bp_wen_%0d", i),  32'(bus.sram_wen),   32'd0);
      check($sformatf("bp_busy_%0d", i), 32'(bus.write_busy), 32'd1);
    end
    bus.start_write = 1'b0;
    hold = 1'b0;
    wait_done("bp_done", 30);
    ew = '{24'h030055, 24'h030055, 24'h030166, 24'h030166};
    check_writes("bp", ew);
    tick();

    // 6: reset during the first strobe cycle of byte 2 of 4
    wr_q.delete();
    prod_q.push_back(8'h01); prod_q.push_back(8'h02);
    prod_q.push_back(8'h03); prod_q.push_back(8'h04);
    bus.base_addr   = 16'h0500;
    bus.byte_count  = 10'd4;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    n = 0;
    while (!(bus.sram_wen && bus.sram_addr == 16'h0501) && n < 30) begin
      tick();
      n++;
    end
    check("mid_reach", 32'(bus.sram_wen && bus.sram_addr == 16'h0501), 32'd1);
    done_before = done_cnt;
    n_rst = 1'b0;
    tick();
    check("mid_wen",   32'(bus.sram_wen),   32'd0);
    check("mid_busy",  32'(bus.write_busy), 32'd0);
    check("mid_ready", 32'(bus.data_ready), 32'd0);
    check("mid_done",  32'(bus.write_done), 32'd0);
    n_rst = 1'b1;
    prod_q.delete();
    for (int i = 0; i < 4; i++) tick();
    check("mid_nodone", 32'(done_cnt), 32'(done_before));
    check("mid_idle",   32'(bus.write_busy), 32'd0);
    wr_q.delete();
    prod_q.push_back(8'h77);
    bus.base_addr   = 16'h0040;
    bus.byte_count  = 10'd1;
    bus.start_write = 1'b1;
    tick();
    bus.start_write = 1'b0;
    wait_done("post_done", 20);
    ew = '{24'h004077, 24'h004077};
    check_writes("post", ew);
    tick();
    check("post_busy", 32'(bus.write_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
